// File: rtl/down_timer.sv
// Loadable down-counting interval timer: counts a captured start value down to
// zero, emits a one-cycle terminal tick, then idles or auto-reloads.
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             tick_q, tick_d;

   // Terminal edge is detected at zero, so the decrement can never wrap.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rld_d   = rld_q;
      tick_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               count_d = load_value;
               rld_d   = load_value;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               count_d = '0;
               state_d = IDLE;
            end else if (!pause) begin
               if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  tick_d = 1'b1;
                  if (auto_reload) begin
                     count_d = rld_q;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         count_q <= '0;
         rld_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rld_q   <= rld_d;
         tick_q  <= tick_d;
      end
   end

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q == RUN);
   assign count      = count_q;
   assign tick       = tick_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH=4): a vector table for the basic
// handshake/stop/pause behaviour plus hand-written multi-cycle sequences.
module tb_down_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             resetn;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             auto_reload;
   logic             pause;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             rn;
      logic             lv;
      logic [WIDTH-1:0] val;
      logic             ar;
      logic             p;
      logic             s;
      logic [WIDTH-1:0] exp_count;
      logic             exp_busy;
      logic             exp_tick;
      logic             exp_ready;
   } vec_t;

   vec_t vecs[21];

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_value  (load_value),
      .auto_reload (auto_reload),
      .pause       (pause),
      .stop        (stop),
      .count       (count),
      .busy        (busy),
      .tick        (tick)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive inputs, advance one rising edge, then settle before sampling.
   task automatic applyStimulus(input logic rn, input logic lv, input logic [WIDTH-1:0] val,
                                input logic ar, input logic p, input logic s);
      resetn      = rn;
      load_valid  = lv;
      load_value  = val;
      auto_reload = ar;
      pause       = p;
      stop        = s;
      @(posedge clk);
      #1;
   endtask

   // Compare all four visible outputs as one check.
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] ec, input logic eb,
                              input logic et, input logic er);
      checks++;
      if (count !== ec || busy !== eb || tick !== et || load_ready !== er) begin
         errors++;
         $display("[TB] FAIL %s: got count=%0d busy=%b tick=%b ready=%b, expected count=%0d busy=%b tick=%b ready=%b",
                  name, count, busy, tick, load_ready, ec, eb, et, er);
      end
   endtask

   function automatic vec_t mk(logic rn, logic lv, logic [WIDTH-1:0] val, logic ar, logic p, logic s,
                               logic [WIDTH-1:0] ec, logic eb, logic et, logic er);
      vec_t v;
      v.rn = rn; v.lv = lv; v.val = val; v.ar = ar; v.p = p; v.s = s;
      v.exp_count = ec; v.exp_busy = eb; v.exp_tick = et; v.exp_ready = er;
      return v;
   endfunction

   initial begin
      int ticks;
      int last_tick;
      logic [WIDTH-1:0] pause_exp[9];

      resetn = 1'b0; load_valid = 1'b0; load_value = '0;
      auto_reload = 1'b0; pause = 1'b0; stop = 1'b0;

      //                rn lv val ar p  s   cnt busy tick rdy
      vecs[0]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      vecs[1]  = mk(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      vecs[2]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      vecs[3]  = mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      vecs[8]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      // Loads during RUN are ignored; pause holds; stop beats pause.
      vecs[9]  = mk(1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
      vecs[13] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      vecs[14] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      // Stop on the terminal edge: no tick even with auto_reload.
      vecs[15] = mk(1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      vecs[16] = mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      vecs[17] = mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      vecs[18] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      // pause/stop do not block a load in IDLE.
      vecs[19] = mk(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      vecs[20] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].rn, vecs[i].lv, vecs[i].val, vecs[i].ar, vecs[i].p, vecs[i].s);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
                     vecs[i].exp_tick, vecs[i].exp_ready);
      end

      // Periodic V=15: ticks at edges 16,32,48,64 after acceptance, reloading to 15.
      $display("[TB] periodic V=15 auto-reload");
      applyStimulus(1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
      checkOutput("per_load", 4'd15, 1'b1, 1'b0, 1'b0);
      ticks = 0;
      last_tick = 0;
      for (int i = 1; i <= 64; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("per_e%0d", i), 4'(15 - (i % 16)), 1'b1, (i % 16) == 0, 1'b0);
         if (tick) begin
            ticks++;
            checks++;
            if (i - last_tick != 16) begin
               errors++;
               $display("[TB] FAIL per_gap: got %0d, expected 16", i - last_tick);
            end
            last_tick = i;
         end
      end
      checks++;
      if (ticks != 4) begin
         errors++;
         $display("[TB] FAIL per_ticks: got %0d, expected 4", ticks);
      end
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("per_stop", 4'd0, 1'b0, 1'b0, 1'b1);

      // V=5, pause for 3 edges at count=2: tick arrives 3 cycles late.
      $display("[TB] pause at count 2");
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      checkOutput("pz_load", 4'd5, 1'b1, 1'b0, 1'b0);
      pause_exp = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, (i >= 3 && i <= 5), 1'b0);
         checkOutput($sformatf("pz_e%0d", i + 1), pause_exp[i], i != 8, i == 8, i == 8);
      end

      // Pause at count=0 defers the terminal event.
      $display("[TB] pause at count 0");
      applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("pz0_load", 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("pz0_hold1", 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("pz0_hold2", 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("pz0_term", 4'd0, 1'b0, 1'b1, 1'b1);

      // V=0 with auto_reload: tick every cycle.
      $display("[TB] V=0 auto-reload");
      applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("v0_load", 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("v0_e%0d", i + 1), 4'd0, 1'b1, 1'b1, 1'b0);
      end
      // auto_reload dropped: the next terminal edge ends the run.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("v0_end", 4'd0, 1'b0, 1'b1, 1'b1);

      // Reset mid-run of V=4 auto-reload at count=1.
      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_load", 4'd4, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_at1", 4'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_hit", 4'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_after", 4'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut.rld_q !== 4'd0) begin
         errors++;
         $display("[TB] FAIL rst_rld: got %0d, expected 0", dut.rld_q);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
